// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave driving a single-port SRAM macro that has a
// registered Q and byte write enables. Reads normally complete with zero wait
// states. Writes always complete with zero wait states, because each write is
// parked in a one-entry write buffer. Buffered bytes are merged into read data
// so that a read always sees the most recent write.
module ahb_sram_ctrl #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic [31:0]   HRDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [AW-1:0] sram_A,
    output logic [31:0]   sram_D,
    output logic          sram_cen,
    output logic [3:0]    sram_wen,
    input  logic [31:0]   sram_Q
);

    typedef enum logic {NORMAL, RD_LATE} state_t;

    state_t        state;
    state_t        state_nxt;

    logic          accept;
    logic          rd_req;
    logic          prio_commit;
    logic          wb_load;
    logic          wb_drain;
    logic [AW-1:0] haddr_word;
    logic [3:0]    addr_be;

    // Data-phase registers: the transfer whose data moves on the bus this cycle
    logic          dp_valid;
    logic          dp_write;
    logic [AW-1:0] dp_addr;
    logic [3:0]    dp_be;

    // One-entry write buffer
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [3:0]    wb_be;
    logic [31:0]   wb_data;

    // Upper address bits select this slave in the interconnect, and HTRANS[0]
    // only separates SEQ from NONSEQ; neither matters inside the block.
    logic          unused_bits;
    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign haddr_word = HADDR[AW+1:2];
    assign accept     = HSEL & HTRANS[1] & HREADY;
    // Speculative read request: an SRAM read with no matching data phase is harmless.
    assign rd_req     = HSEL & HTRANS[1] & ~HWRITE;
    // A write data phase with an occupied buffer must commit the old entry now,
    // because the buffer is refilled at the end of this same cycle.
    assign prio_commit = dp_valid & dp_write & wb_valid;
    assign wb_load     = dp_valid & dp_write & HREADYOUT;
    assign HRESP       = 1'b0;

    // Byte-lane enables of the transfer in its address phase
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no branch can leave it unassigned and infer a latch.
        addr_be = 4'b1111;
        case (HSIZE)
            3'd0:    addr_be = 4'b0001 << HADDR[1:0];
            3'd1:    addr_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default: addr_be = 4'b1111;
        endcase
    end

    // Capture the accepted address phase as the next data phase
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, whatever the block order.
        if (!rst_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
        end else if (HREADY) begin
            dp_valid <= accept;
            dp_write <= accept & HWRITE;
        end
        // NOTE: address and lane registers are qualified by the valid bits, so they carry no reset.
        if (HREADY) begin
            dp_addr <= haddr_word;
            dp_be   <= addr_be;
        end
    end

    // Write buffer: filled at the end of each write data phase, emptied by an idle-slot commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
        end else if (wb_load) begin
            wb_valid <= 1'b1;
        end else if (wb_drain) begin
            wb_valid <= 1'b0;
        end
        if (wb_load) begin
            wb_addr <= dp_addr;
            wb_be   <= dp_be;
            wb_data <= HWDATA;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a read that loses the SRAM port to a buffer commit takes one wait state
    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL:  if (accept & ~HWRITE & prio_commit) state_nxt = RD_LATE;
            RD_LATE: state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    // FSM outputs: SRAM port arbitration (one access per cycle) and bus ready
    always_comb begin
        HREADYOUT = (state == NORMAL);
        sram_A    = haddr_word;
        sram_D    = wb_data;
        sram_cen  = 1'b0;
        sram_wen  = 4'b0000;
        wb_drain  = 1'b0;
        if (state == RD_LATE) begin
            // Late read of the stalled data phase; the held address phase waits.
            sram_A = dp_addr;
        end else if (prio_commit) begin
            sram_A   = wb_addr;
            sram_cen = 1'b1;
            sram_wen = wb_be;
        end else if (rd_req) begin
            sram_A = haddr_word;
        end else if (wb_valid) begin
            sram_A   = wb_addr;
            sram_cen = 1'b1;
            sram_wen = wb_be;
            wb_drain = 1'b1;
        end
    end

    // Read data: SRAM word with buffered bytes of the same word overlaid
    always_comb begin
        HRDATA = sram_Q;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid && (wb_addr == dp_addr) && wb_be[i]) begin
                HRDATA[i*8 +: 8] = wb_data[i*8 +: 8];
            end
        end
    end

endmodule

// File: doc/ahb_sram_ctrl.md
# ahb_sram_ctrl

AHB-Lite slave that acts as the initiator on the single-port SRAM macro interface (SRAM_8Kx32-style, with a registered Q and byte write enables). It turns bus reads and writes into SRAM port cycles. Reads normally complete with zero wait states. Writes always complete with zero wait states, because each write goes through a one-entry write buffer with read-data merging. The block sits between the AHB-Lite interconnect and one SRAM instance in the SoC memory map.

## Interface
- AW, 13, SRAM word-address width; the word address is HADDR[AW+1:2]
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; values above 2 are treated as word
- HREADY  in  1  bus-level ready
- HWDATA  in  32  write data, valid in the data phase
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  constant 0 (OKAY)
- sram_A  out  AW  SRAM word address
- sram_D  out  32  SRAM write data
- sram_cen  out  1  SRAM write enable, active-high; held 0 on reads
- sram_wen  out  4  per-byte write enables, active-high
- sram_Q  in  32  SRAM read data, valid one cycle after sram_A is presented

## Operation
- **Accept.** A transfer is accepted when HSEL & HTRANS[1] & HREADY. The accepted transfer loads the data-phase registers: dp_valid, dp_write, dp_addr (word address) and dp_be.
- **Byte lanes.** dp_be is derived from HSIZE and HADDR[1:0].
  - Byte: one lane, selected by HADDR[1:0].
  - Halfword: 4'b0011 if HADDR[1]=0, 4'b1100 if HADDR[1]=1.
  - Word: 4'b1111.
- **Write buffer.** Registers wb_valid, wb_addr, wb_be and wb_data.
  - At the end of every write data phase with HREADYOUT=1, HWDATA, dp_addr and dp_be are loaded into the buffer and wb_valid is set.
- **Read request.** rd_req = HSEL & HTRANS[1] & ~HWRITE. It deliberately does not depend on HREADY; a speculative SRAM read is harmless.
- **SRAM port arbitration** (one access per cycle), highest priority first:
  1. State RD_LATE: read dp_addr.
  2. dp_write & wb_valid: commit the buffer (drive sram_A = wb_addr, sram_D = wb_data, sram_wen = wb_be). The buffer is refilled at the end of the same cycle.
  3. rd_req: read the word address of HADDR.
  4. wb_valid: commit the buffer and clear wb_valid.
  5. Otherwise idle: sram_wen = 0.
- **sram_cen.** sram_cen = 1 only on write commits. The SRAM read path needs no enable.
- **States.**
  - NORMAL to RD_LATE: a read is accepted in a cycle where rd_req lost arbitration to priority 2.
  - RD_LATE to NORMAL: always, after one cycle.
- **HRDATA.** HRDATA = sram_Q, with each lane i replaced by wb_data lane i when wb_valid & wb_addr == dp_addr & wb_be[i]. This merge gives read-after-write coherency for buffered data.
- **Other transfers.** IDLE/BUSY transfers and HSEL=0 create no data phase and no SRAM access.
- **Reset.** While rst_n=0 the buffer is discarded.

## Timing
- **Reset values:** HREADYOUT=1, HRESP=0, sram_cen=0, sram_wen=0, wb_valid=0, dp_valid=0, state NORMAL. HRDATA is don't-care while there is no read data phase.
- **Read latency:** address phase in cycle N, data in cycle N+1, zero waits. In the RD_LATE case there is exactly 1 wait state: HREADYOUT=0 in N+1, and data is valid in N+2.
- **Write latency:** always zero wait states on the bus. The SRAM commit occurs no earlier than the cycle after the data phase.
- **Back-to-back writes:** an older buffer entry commits in the same cycle the newer data phase ends. No data is lost and there is no stall.
- **Read to a just-written address:** the merge returns the new data in the immediately following data phase.
- **During an RD_LATE wait cycle:** the held address phase on the bus does not issue a read. It is issued the next cycle.
- **Reset mid-transfer:** rst_n=0 at any edge returns the block to reset values at that edge. An uncommitted buffered write is dropped.

## Test plan
- Reset: rst_n=0 for 3 cycles with HSEL=1 and HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, sram_cen=0 throughout; no SRAM write after release.
- Word write 0xDEADBEEF at 0x10, 2 idle cycles, then read 0x10:
  - sram_cen=1, sram_wen=4'hF, sram_A=4 in the cycle after the data phase.
  - HRDATA=0xDEADBEEF with zero waits.
- Word 0x11223344 at 0x10, then byte write 0xAB at 0x13 (HSIZE=0), then read 0x10 -> sram_wen=4'b1000; HRDATA=0xAB223344.
- Write 0x5555AAAA to 0x20 immediately followed by read 0x20 -> HRDATA=0x5555AAAA via merge, HREADYOUT stays 1.
- Back-to-back W 0x0=1, W 0x4=2, R 0x8 (memory holds 0x77):
  - Both writes complete with zero waits.
  - The read takes 1 wait state and returns 0x77.
  - Subsequent reads of 0x0 and 0x4 return 1 and 2.
- Halfword write 0x1234 at 0x22 (old word 0) followed by continuous reads of 0x40, with rst_n=0 for one cycle during the 2nd read -> read of 0x20 after reset returns 0x00000000.
